// File: rtl/card_dealer.sv
// card_dealer -- read-side companion to the deck shuffler.
// Once the deck RAM holds a shuffled deck, each deal request reads the next
// sequential RAM word and presents the card code to the game FSM.
// The block is read-only and never drives RAM write enable or write data.
//
// Optional feature macro: CARD_POINTS_EN adds the card_points output, which
// holds the blackjack value of the card and is registered together with card.
//
// Ports:
//   clock        system clock, all state on the rising edge
//   reset_n      asynchronous active-low reset
//   start        1 = dealing enabled; 0 = go to IDLE and rewind the deck
//   deal_req     request the next card (sampled only in READY)
//   memData      RAM read data
//   nextA        registered RAM address
//   memClock     RAM clock strobe, high for the whole READ state
//   card         last dealt card code, held until the next deal
//   card_valid   one-cycle pulse when card is updated
//   cards_dealt  cards dealt since the last rewind
//   busy         high in SET_ADDR / READ / CAPTURE
//   deck_empty   high once DECK_SIZE cards have been dealt
//   card_points  (CARD_POINTS_EN only) points value of card
module card_dealer #(
    parameter int DECK_SIZE = 52,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              deal_req,
    input  logic [DATA_W-1:0] memData,
    output logic [ADDR_W-1:0] nextA,
    output logic              memClock,
    output logic [DATA_W-1:0] card,
    output logic              card_valid,
    output logic [ADDR_W-1:0] cards_dealt,
    output logic              busy,
    output logic              deck_empty
`ifdef CARD_POINTS_EN
    ,
    output logic [4:0]        card_points
`endif
);

    typedef enum logic [2:0] {
        IDLE, READY, SET_ADDR, READ, CAPTURE, EMPTY
    } state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    // Count value just before the final card; reaching it in CAPTURE ends the deck.
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DECK_SIZE - 1);

    state_t state, state_nxt;

    // cards_dealt doubles as the read pointer: the next card lives at BASE + count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!start) begin
            // Dropping start wins over everything, including an in-flight read.
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:     state_nxt = READY;
                READY:    if (deal_req) state_nxt = SET_ADDR;
                SET_ADDR: state_nxt = READ;
                READ:     state_nxt = CAPTURE;
                CAPTURE:  state_nxt = (cards_dealt == LAST) ? EMPTY : READY;
                EMPTY:    state_nxt = EMPTY;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    assign memClock = (state == READ);
    assign busy     = (state == SET_ADDR) || (state == READ) || (state == CAPTURE);

`ifdef CARD_POINTS_EN
    function automatic logic [4:0] points_of(input logic [DATA_W-1:0] c);
        logic [4:0] p;
        p = 5'd0;
        if (c == DATA_W'(1))                             p = 5'd11;
        else if (c >= DATA_W'(11) && c <= DATA_W'(13))   p = 5'd10;
        else if (c >= DATA_W'(2) && c <= DATA_W'(10))    p = 5'(c);
        return p;
    endfunction
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            nextA       <= BASE;
            card        <= '0;
            card_valid  <= 1'b0;
            cards_dealt <= '0;
            deck_empty  <= 1'b0;
`ifdef CARD_POINTS_EN
            card_points <= 5'd0;
`endif
        end else begin
            card_valid <= 1'b0;
            if (!start || state == IDLE) begin
                // Rewind; card (and its points) keep their last value.
                nextA       <= BASE;
                cards_dealt <= '0;
                deck_empty  <= 1'b0;
            end else begin
                case (state)
                    READY: if (deal_req) nextA <= BASE + cards_dealt;
                    CAPTURE: begin
                        card        <= memData;
                        card_valid  <= 1'b1;
                        cards_dealt <= cards_dealt + 1'b1;
                        if (cards_dealt == LAST) deck_empty <= 1'b1;
`ifdef CARD_POINTS_EN
                        card_points <= points_of(memData);
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: stimulus pushes expected deals into a
// queue, a negedge monitor pops and compares on every card_valid pulse.
module tb_card_dealer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic       deal_req;
    logic [3:0] memData = 4'd0;
    logic [5:0] nextA;
    logic       memClock;
    logic [3:0] card;
    logic       card_valid;
    logic [5:0] cards_dealt;
    logic       busy;
    logic       deck_empty;
`ifdef CARD_POINTS_EN
    logic [4:0] card_points;
`endif

    card_dealer dut (
        .clock(clock), .reset_n(reset_n), .start(start), .deal_req(deal_req),
        .memData(memData), .nextA(nextA), .memClock(memClock), .card(card),
        .card_valid(card_valid), .cards_dealt(cards_dealt), .busy(busy),
        .deck_empty(deck_empty)
`ifdef CARD_POINTS_EN
        , .card_points(card_points)
`endif
    );

    always #5 clock = ~clock;

    logic [3:0] ram [64];
    // RAM registers the read on the memClock strobe.
    always @(posedge memClock) memData <= ram[nextA];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] card;
        logic [5:0] dealt;
        logic       empty;
        logic [5:0] addr;
        logic [4:0] pts;
        int         at_cyc;
    } exp_t;
    exp_t q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor
    always @(negedge clock) begin
        if (card_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_card_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("card", card, e.card);
                chk("cards_dealt", cards_dealt, e.dealt);
                chk("deck_empty", deck_empty, e.empty);
                chk("addr", nextA, e.addr);
                chk("pulse_cycle", cyc, e.at_cyc);
`ifdef CARD_POINTS_EN
                chk("card_points", card_points, e.pts);
`endif
            end
        end
    end

    function automatic logic [4:0] pts_of(input logic [3:0] c);
        if (c == 4'd1) return 5'd11;
        if (c >= 4'd11 && c <= 4'd13) return 5'd10;
        if (c >= 4'd2 && c <= 4'd10) return {1'b0, c};
        return 5'd0;
    endfunction

    function automatic exp_t mk(input logic [3:0] c, input int dealt, input logic empty,
                                input int addr, input int at);
        exp_t e;
        e.card = c; e.dealt = 6'(dealt); e.empty = empty; e.addr = 6'(addr);
        e.pts = pts_of(c); e.at_cyc = at;
        return e;
    endfunction

    // Wait until the scoreboard drains, bounded.
    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clock); #1;
            n++;
        end
        if (q.size() != 0) begin
            chk({name, "_timeout"}, q.size(), 0);
            q.delete();
        end
    endtask

    // Leaves the DUT in READY at a negedge with the deck rewound.
    task automatic rewind();
        @(negedge clock); start = 1'b0;
        @(negedge clock); start = 1'b1;
        @(negedge clock);
    endtask

    // One-cycle request from READY; expects the card 4 negedges later.
    task automatic deal_one(input logic [3:0] c, input int dealt, input int addr);
        @(negedge clock);
        deal_req = 1'b1;
        q.push_back(mk(c, dealt, 1'b0, addr, cyc + 4));
        @(negedge clock);
        deal_req = 1'b0;
        drain("deal_one", 20);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 64; i++) ram[i] = 4'((i % 13) + 1);
        reset_n = 1'b0; start = 1'b0; deal_req = 1'b0;
        #1;
        chk("rst_nextA", nextA, 0);
        chk("rst_card", card, 0);
        chk("rst_valid", card_valid, 0);
        chk("rst_dealt", cards_dealt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_empty", deck_empty, 0);
        chk("rst_memClock", memClock, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Single deal with latency / strobe checks
        ram[0] = 4'd7;
        @(negedge clock); start = 1'b1;
        @(negedge clock);
        k = cyc;
        deal_req = 1'b1;
        q.push_back(mk(4'd7, 1, 1'b0, 0, k + 4));
        @(negedge clock); deal_req = 1'b0;
        chk("t2_setaddr_memClock", memClock, 0);
        chk("t2_setaddr_busy", busy, 1);
        chk("t2_nextA", nextA, 0);
        @(negedge clock);
        chk("t2_read_memClock", memClock, 1);
        @(negedge clock);
        chk("t2_capture_memClock", memClock, 0);
        drain("t2", 10);
        ram[0] = 4'd1;

        // Full deck with deal_req held high
        rewind();
        k = cyc;
        deal_req = 1'b1;
        for (int i = 0; i < 52; i++)
            q.push_back(mk(4'((i % 13) + 1), i + 1, i == 51, i, k + 4 + 4 * i));
        drain("t3", 260);
        repeat (12) @(negedge clock);
        chk("t3_deck_empty_hold", deck_empty, 1);
        chk("t3_dealt_final", cards_dealt, 52);
        chk("t3_busy_in_empty", busy, 0);
        deal_req = 1'b0;

        // Requests during busy are ignored
        rewind();
        k = cyc;
        deal_req = 1'b1;
        q.push_back(mk(4'd1, 1, 1'b0, 0, k + 4));
        @(negedge clock); deal_req = 1'b1;   // sampled in SET_ADDR
        @(negedge clock); deal_req = 1'b0;
        @(negedge clock); deal_req = 1'b1;   // sampled in CAPTURE
        @(negedge clock); deal_req = 1'b0;
        drain("t4", 10);
        repeat (8) @(negedge clock);
        chk("t4_dealt", cards_dealt, 1);

        // start dropped mid-read, then rewound deal
        deal_one(4'd2, 2, 1);
        @(negedge clock);
        deal_req = 1'b1;
        @(negedge clock); deal_req = 1'b0;
        chk("t5_nextA_second", nextA, 2);
        @(negedge clock);
        chk("t5_in_read", memClock, 1);
        start = 1'b0;
        @(negedge clock);
        chk("t5_busy", busy, 0);
        chk("t5_dealt", cards_dealt, 0);
        chk("t5_card_kept", card, 2);
        chk("t5_memClock", memClock, 0);
        start = 1'b1;
        @(negedge clock);
        deal_one(4'd1, 1, 0);

`ifdef CARD_POINTS_EN
        ram[0] = 4'd1; ram[1] = 4'd12; ram[2] = 4'd5; ram[3] = 4'd0;
        rewind();
        deal_one(4'd1, 1, 0);
        deal_one(4'd12, 2, 1);
        deal_one(4'd5, 3, 2);
        deal_one(4'd0, 4, 3);
        ram[0] = 4'd1; ram[1] = 4'd2; ram[2] = 4'd3; ram[3] = 4'd4;
`endif

        // Reset asserted mid-READ
        rewind();
        deal_req = 1'b1;
        @(negedge clock); deal_req = 1'b0;
        @(negedge clock);
        chk("t1_pre_memClock", memClock, 1);
        reset_n = 1'b0;
        #1;
        chk("t1_nextA", nextA, 0);
        chk("t1_card", card, 0);
        chk("t1_valid", card_valid, 0);
        chk("t1_dealt", cards_dealt, 0);
        chk("t1_busy", busy, 0);
        chk("t1_empty", deck_empty, 0);
        chk("t1_memClock", memClock, 0);
        repeat (4) @(negedge clock);
        chk("t1_no_pending", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
